// File: rtl/cu_vertex_cache_data_merge.sv
// cu_vertex_cache_data_merge
//
// Gathers the three independently timed pieces of a vertex cache read
// (response tag/offset, half-line 0, half-line 1) into capture slots. Once
// all three are present, it extracts the addressed vertex word from the
// line. The {tag, word} pair then goes into a show-ahead output FIFO.
//
// Ports
//   clock          rising-edge clock
//   rstn_in        asynchronous active-low reset
//   enabled_in     capture enable; the FIFO drains regardless of this input
//   rsp_valid_in   response strobe, together with rsp_tag_in / rsp_offset_in
//   data0_valid_in half-line 0 strobe; data0_in holds words 0..WORDS/2-1
//   data1_valid_in half-line 1 strobe; data1_in holds words WORDS/2..WORDS-1
//                  (half-lines are ascending vectors, word 0 in the leftmost bits)
//   out_valid/out_ready/out_tag/out_data  show-ahead FIFO head and handshake
//   count_out      FIFO occupancy (0..DEPTH)
//   full_out       occupancy equals DEPTH
//   drop_err_out   sticky: a strobe hit an occupied slot and was lost
//
// DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.

module cu_vertex_cache_data_merge #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned HALF_W = 512,
  parameter  int unsigned TAG_W  = 8,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned WORDS  = 2 * HALF_W / DATA_W,
  localparam int unsigned OFF_W  = $clog2(WORDS),
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               rstn_in,
  input  logic               enabled_in,
  input  logic               rsp_valid_in,
  input  logic [TAG_W-1:0]   rsp_tag_in,
  input  logic [OFF_W-1:0]   rsp_offset_in,
  input  logic               data0_valid_in,
  input  logic [0:HALF_W-1]  data0_in,
  input  logic               data1_valid_in,
  input  logic [0:HALF_W-1]  data1_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   out_tag,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   count_out,
  output logic               full_out,
  output logic               drop_err_out
);

  localparam int unsigned HALF_WORDS = WORDS / 2;
  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W    = TAG_W + DATA_W;

  // ---------------------------------------------------------------------------
  // Capture slots
  // ---------------------------------------------------------------------------
  logic              rsp_full, d0_full, d1_full;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [OFF_W-1:0]  rsp_off_q;
  logic [0:HALF_W-1] d0_q, d1_q;

  logic merge_ready, merge_fire, fifo_accept, pop;
  logic rsp_strobe, d0_strobe, d1_strobe;
  logic rsp_load, d0_load, d1_load;
  logic any_drop;

  assign rsp_strobe = enabled_in & rsp_valid_in;
  assign d0_strobe  = enabled_in & data0_valid_in;
  assign d1_strobe  = enabled_in & data1_valid_in;

  assign merge_ready = rsp_full & d0_full & d1_full;
  assign merge_fire  = merge_ready & fifo_accept;

  // A slot that is being released at this edge may be reloaded at the same
  // edge. This lets back-to-back merges run at one per cycle.
  assign rsp_load = rsp_strobe & (~rsp_full | merge_fire);
  assign d0_load  = d0_strobe  & (~d0_full  | merge_fire);
  assign d1_load  = d1_strobe  & (~d1_full  | merge_fire);

  assign any_drop = (rsp_strobe & ~rsp_load) |
                    (d0_strobe  & ~d0_load)  |
                    (d1_strobe  & ~d1_load);

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      rsp_full     <= 1'b0;
      d0_full      <= 1'b0;
      d1_full      <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_off_q    <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      drop_err_out <= 1'b0;
    end else begin
      if (rsp_load) begin
        rsp_full  <= 1'b1;
        rsp_tag_q <= rsp_tag_in;
        rsp_off_q <= rsp_offset_in;
      end else if (merge_fire) begin
        rsp_full <= 1'b0;
      end

      if (d0_load) begin
        d0_full <= 1'b1;
        d0_q    <= data0_in;
      end else if (merge_fire) begin
        d0_full <= 1'b0;
      end

      if (d1_load) begin
        d1_full <= 1'b1;
        d1_q    <= data1_in;
      end else if (merge_fire) begin
        d1_full <= 1'b0;
      end

      if (any_drop) begin
        drop_err_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word extraction. The offset MSB selects the half-line. The remaining bits
  // index a word inside it, with word 0 in the leftmost (lowest-numbered) bits.
  // ---------------------------------------------------------------------------
  logic [OFF_W-2:0]  half_idx;
  logic [DATA_W-1:0] sel_word;

  assign half_idx = rsp_off_q[OFF_W-2:0];

  always_comb begin
    sel_word = '0;
    for (int unsigned w = 0; w < HALF_WORDS; w++) begin
      if (half_idx == (OFF_W-1)'(w)) begin
        sel_word = rsp_off_q[OFF_W-1] ? d1_q[w*DATA_W +: DATA_W]
                                      : d0_q[w*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_full;
  logic [ENTRY_W-1:0] head;

  assign fifo_full   = (count_q == CNT_W'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  // When the FIFO is full it still accepts a push, provided a pop frees a
  // slot at the same edge.
  assign fifo_accept = ~fifo_full | pop;

  always_ff @(posedge clock) begin
    if (merge_fire) begin
      mem[wr_ptr] <= {rsp_tag_q, sel_word};
    end
  end

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (merge_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      case ({merge_fire, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  // This keeps out_tag and out_data at zero during reset.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_tag   = head[ENTRY_W-1:DATA_W];
  assign out_data  = head[DATA_W-1:0];
  assign count_out = count_q;
  assign full_out  = fifo_full;

endmodule

// File: tb/tb_cu_vertex_cache_data_merge.sv
// Testbench for cu_vertex_cache_data_merge.
// The reference model tracks each slot as an occupied flag plus contents.
// It holds the line as an array of words and uses a queue for the FIFO.
// Directed scenarios are followed by a randomized phase.

module tb_cu_vertex_cache_data_merge;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 512;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WORDS  = 2 * HALF_W / DATA_W;
  localparam int unsigned HW     = WORDS / 2;
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              rstn_in;
  logic              enabled_in;
  logic              rsp_valid_in;
  logic [TAG_W-1:0]  rsp_tag_in;
  logic [OFF_W-1:0]  rsp_offset_in;
  logic              data0_valid_in;
  logic [0:HALF_W-1] data0_in;
  logic              data1_valid_in;
  logic [0:HALF_W-1] data1_in;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count_out;
  logic              full_out;
  logic              drop_err_out;

  cu_vertex_cache_data_merge #(
    .DATA_W(DATA_W), .HALF_W(HALF_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in),
    .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_offset_in(rsp_offset_in),
    .data0_valid_in(data0_valid_in), .data0_in(data0_in),
    .data1_valid_in(data1_valid_in), .data1_in(data1_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .count_out(count_out), .full_out(full_out), .drop_err_out(drop_err_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus words; word i of each half-line is w0[i] / w1[i].
  logic [DATA_W-1:0] w0 [HW];
  logic [DATA_W-1:0] w1 [HW];

  // Reference model state
  bit                m_r_occ, m_d0_occ, m_d1_occ, m_drop;
  logic [TAG_W-1:0]  m_r_tag;
  int unsigned       m_r_off;
  logic [DATA_W-1:0] m_d0w [HW];
  logic [DATA_W-1:0] m_d1w [HW];
  logic [TAG_W+DATA_W-1:0] mq [$];

  task automatic model_reset();
    m_r_occ = 0; m_d0_occ = 0; m_d1_occ = 0; m_drop = 0;
    mq.delete();
  endtask

  task automatic model_step();
    bit pop, fire;
    logic [DATA_W-1:0] word;
    pop  = (mq.size() != 0) && out_ready;
    fire = m_r_occ && m_d0_occ && m_d1_occ && (mq.size() < DEPTH || pop);
    word = (m_r_off < HW) ? m_d0w[m_r_off] : m_d1w[m_r_off - HW];
    if (pop)  void'(mq.pop_front());
    if (fire) mq.push_back({m_r_tag, word});
    if (enabled_in && rsp_valid_in) begin
      if (!m_r_occ || fire) begin
        m_r_occ = 1; m_r_tag = rsp_tag_in; m_r_off = rsp_offset_in;
      end else m_drop = 1;
    end else if (fire) m_r_occ = 0;
    if (enabled_in && data0_valid_in) begin
      if (!m_d0_occ || fire) begin
        m_d0_occ = 1; m_d0w = w0;
      end else m_drop = 1;
    end else if (fire) m_d0_occ = 0;
    if (enabled_in && data1_valid_in) begin
      if (!m_d1_occ || fire) begin
        m_d1_occ = 1; m_d1w = w1;
      end else m_drop = 1;
    end else if (fire) m_d1_occ = 0;
  endtask

  task automatic compare_all();
    logic [TAG_W+DATA_W-1:0] h;
    check("valid", out_valid, mq.size() != 0);
    check("count", count_out, mq.size());
    check("full", full_out, mq.size() == DEPTH);
    check("drop", drop_err_out, m_drop);
    if (mq.size() != 0) begin
      h = mq[0];
      check("tag", out_tag, h[TAG_W+DATA_W-1:DATA_W]);
      check("data", out_data, h[DATA_W-1:0]);
    end
  endtask

  // Word 0 ends up in the most significant (leftmost) position.
  task automatic pack();
    logic [HALF_W-1:0] t0, t1;
    t0 = '0; t1 = '0;
    for (int i = 0; i < HW; i++) begin
      t0 = (t0 << DATA_W) | HALF_W'(w0[i]);
      t1 = (t1 << DATA_W) | HALF_W'(w1[i]);
    end
    data0_in = t0;
    data1_in = t1;
  endtask

  task automatic rand_words();
    for (int i = 0; i < HW; i++) begin
      w0[i] = $urandom;
      w1[i] = $urandom;
    end
  endtask

  task automatic drive(input bit en, input bit rv, input int tag, input int off,
                       input bit v0, input bit v1, input bit rdy);
    enabled_in = en; rsp_valid_in = rv; rsp_tag_in = TAG_W'(tag);
    rsp_offset_in = OFF_W'(off); data0_valid_in = v0; data1_valid_in = v1;
    out_ready = rdy;
    pack();
  endtask

  // One clock: the model advances at the edge, and outputs are compared at
  // the following falling edge.
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    drive(1, 0, 0, 0, 0, 0, rdy);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rstn_in = 0;
    rand_words();
    drive(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_count", count_out, 0);
    check("rst_full", full_out, 0);
    check("rst_tag", out_tag, 0);
    check("rst_data", out_data, 0);
    check("rst_drop", drop_err_out, 0);
    @(negedge clock);
    rstn_in = 1;
    cycle();

    // Basic merge
    rand_words();
    w0[3] = 32'hDEADBEEF;
    drive(1, 1, 8'h12, 3, 1, 1, 1);
    cycle();
    check("basic_lat0", out_valid, 0);
    idle(1, 1);
    check("basic_valid", out_valid, 1);
    check("basic_tag", out_tag, 8'h12);
    check("basic_data", out_data, 32'hDEADBEEF);
    check("basic_count", count_out, 1);
    idle(1, 1);
    check("basic_count_after", count_out, 0);

    // Out-of-order arrival
    rand_words();
    w1[1] = 32'hCAFE0001;
    drive(1, 0, 0, 0, 0, 1, 1); cycle();
    idle(3, 1);
    drive(1, 1, 8'h34, 17, 0, 0, 1); cycle();
    idle(1, 1);
    drive(1, 0, 0, 0, 1, 0, 1); cycle();
    check("ooo_lat0", out_valid, 0);
    idle(1, 1);
    check("ooo_valid", out_valid, 1);
    check("ooo_data", out_data, 32'hCAFE0001);
    check("ooo_tag", out_tag, 8'h34);
    check("ooo_drop", drop_err_out, 0);
    idle(2, 1);

    // Backpressure: nine merges into an eight-entry FIFO
    for (int i = 0; i < 9; i++) begin
      rand_words();
      drive(1, 1, 8'h40 + i, $urandom_range(WORDS - 1), 1, 1, 0);
      cycle();
    end
    idle(2, 0);
    check("bp_count", count_out, 8);
    check("bp_full", full_out, 1);
    check("bp_head", out_tag, 8'h40);
    idle(1, 1);
    check("bp_count_pulse", count_out, 8);
    check("bp_head2", out_tag, 8'h41);
    idle(10, 1);
    check("bp_drained", count_out, 0);

    // Overrun: the second response is dropped, and the first one is kept
    rand_words();
    drive(1, 1, 8'h55, 5, 0, 0, 1); cycle();
    drive(1, 1, 8'h66, 20, 0, 0, 1); cycle();
    check("ovr_drop", drop_err_out, 1);
    drive(1, 0, 0, 0, 1, 1, 1); cycle();
    idle(1, 1);
    check("ovr_tag", out_tag, 8'h55);
    check("ovr_data", out_data, w0[5]);
    idle(2, 1);

    // Disable: strobes are ignored, and the FIFO still drains
    drive(0, 1, 8'h77, 1, 1, 1, 1); cycle();
    idle(3, 1);
    check("dis_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      rand_words();
      drive(1, 1, 8'h80 + i, $urandom_range(WORDS - 1), 1, 1, 0);
      cycle();
    end
    idle(1, 0);
    check("dis_count3", count_out, 3);
    drive(0, 1, 8'h99, 2, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle();
    check("dis_drained", count_out, 0);
    check("dis_valid_end", out_valid, 0);
    idle(2, 1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      rand_words();
      drive(1, 1, 8'hA0 + i, i, 1, 1, 0);
      cycle();
    end
    idle(1, 0);
    drive(1, 0, 0, 0, 1, 0, 0); cycle();
    check("mid_count5", count_out, 5);
    drive(1, 0, 0, 0, 0, 0, 0);
    rstn_in = 0;
    #1;
    model_reset();
    check("mid_rst_count", count_out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_full", full_out, 0);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_drop", drop_err_out, 0);
    @(negedge clock);
    rstn_in = 1;
    drive(1, 1, 8'hB0, 20, 0, 1, 1); cycle();
    idle(4, 1);
    check("mid_no_output", out_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rand_words();
      drive($urandom_range(9) != 0, $urandom_range(2) == 0, $urandom_range(255),
            $urandom_range(WORDS - 1), $urandom_range(2) == 0,
            $urandom_range(2) == 0, $urandom_range(3) != 0);
      cycle();
    end
    idle(12, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
